ram_port_arbiter: RTL

- Shares the single 32-bit read/write port A of the 8192x32 dual-port data RAM between two masters.
- Master 0: high-priority, read-only streaming client (video character/attribute fetcher).
- Master 1: j1 CPU data port (read/write).
- Per-cycle fixed-priority grant with starvation override and bounded bus-lock for multi-word bursts; port B (instruction fetch) is untouched.

---
 rtl/ram_port_arbiter_pkg.sv | 19 +
 rtl/ram_port_arbiter_if.sv | 42 ++++
 rtl/ram_port_arbiter.sv | 123 ++++++++++++
 3 files changed

// File: rtl/ram_port_arbiter_pkg.sv
// Shared constants for the data-RAM port A arbiter: bus widths used by the
// memory map and the arbiter FSM state encoding.
package ram_port_arbiter_pkg;

    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;

    localparam logic [1:0] ARB_FREE  = 2'd0;
    localparam logic [1:0] ARB_HOLD0 = 2'd1;
    localparam logic [1:0] ARB_HOLD1 = 2'd2;

    // Request fields common to both masters, so grant logic treats them alike
    typedef struct packed {
        logic              req;
        logic              lock;
        logic [ADDR_W-1:0] addr;
    } arb_req_t;

endpackage

// File: rtl/ram_port_arbiter_if.sv
// Bundle of both master handshakes plus the RAM port A wiring.
// The arbiter sits on the slave side; clients and the RAM sit on the master side.
interface ram_port_arbiter_if;
    import ram_port_arbiter_pkg::*;

    logic              m0_req;
    logic              m0_lock;
    logic [ADDR_W-1:0] m0_addr;
    logic              m0_gnt;
    logic              m0_rvalid;

    logic              m1_req;
    logic              m1_wr;
    logic              m1_lock;
    logic [ADDR_W-1:0] m1_addr;
    logic [DATA_W-1:0] m1_d;
    logic              m1_gnt;
    logic              m1_rvalid;

    logic [DATA_W-1:0] rdata;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;
    logic [DATA_W-1:0] ram_d;
    logic [DATA_W-1:0] ram_q;

    modport master (
        output m0_req, m0_lock, m0_addr,
        output m1_req, m1_wr, m1_lock, m1_addr, m1_d,
        output ram_q,
        input  m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        input  rdata, ram_addr, ram_wr, ram_d
    );

    modport slave (
        input  m0_req, m0_lock, m0_addr,
        input  m1_req, m1_wr, m1_lock, m1_addr, m1_d,
        input  ram_q,
        output m0_gnt, m0_rvalid, m1_gnt, m1_rvalid,
        output rdata, ram_addr, ram_wr, ram_d
    );

endinterface

// File: rtl/ram_port_arbiter.sv
// Shares data-RAM port A between the video fetcher (m0, priority) and the j1
// CPU data port (m1), with starvation override and bounded burst locking.
module ram_port_arbiter
    import ram_port_arbiter_pkg::*;
#(
    parameter int MAX_STARVE = 4,
    parameter int MAX_HOLD   = 8
) (
    input  logic               clk,
    input  logic               resetq,
    ram_port_arbiter_if.slave  bus
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam int HW = $clog2(MAX_HOLD + 1);

    arb_req_t          r0;
    arb_req_t          r1;
    logic [1:0]        state;
    logic [SW-1:0]     starve;
    logic [HW-1:0]     hold;
    logic [ADDR_W-1:0] last_addr;
    logic              m0_rvalid_q;
    logic              m1_rvalid_q;
    logic              gnt0;
    logic              gnt1;
    logic              starve_max;
    logic              hold_last;

    assign r0 = '{req: bus.m0_req, lock: bus.m0_lock, addr: bus.m0_addr};
    assign r1 = '{req: bus.m1_req, lock: bus.m1_lock, addr: bus.m1_addr};

    assign starve_max = (starve == SW'(MAX_STARVE));
    assign hold_last  = (hold == HW'(MAX_HOLD - 1));

    // Grants are gated by resetq so nothing reaches the RAM while in reset
    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (resetq) begin
            case (state)
                ARB_FREE: begin
                    if (r0.req && !(r1.req && starve_max))
                        gnt0 = 1'b1;
                    else if (r1.req)
                        gnt1 = 1'b1;
                end
                ARB_HOLD0: gnt0 = r0.req;
                ARB_HOLD1: gnt1 = r1.req;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge resetq) begin
        if (!resetq) begin
            state       <= ARB_FREE;
            starve      <= '0;
            hold        <= '0;
            last_addr   <= '0;
            m0_rvalid_q <= 1'b0;
            m1_rvalid_q <= 1'b0;
        end else begin
            m0_rvalid_q <= gnt0;
            m1_rvalid_q <= gnt1 & ~bus.m1_wr;

            if (gnt0)
                last_addr <= r0.addr;
            else if (gnt1)
                last_addr <= r1.addr;

            // A forced end of an m0 burst hands the next free cycle to a waiting m1
            if (!r1.req || gnt1)
                starve <= '0;
            else if (state == ARB_HOLD0 && gnt0 && r0.lock && hold_last)
                starve <= SW'(MAX_STARVE);
            else if (state == ARB_FREE && gnt0 && !starve_max)
                starve <= starve + SW'(1);

            case (state)
                ARB_FREE: begin
                    if (gnt0 && r0.lock && MAX_HOLD > 1) begin
                        state <= ARB_HOLD0;
                        hold  <= HW'(1);
                    end else if (gnt1 && r1.lock && MAX_HOLD > 1) begin
                        state <= ARB_HOLD1;
                        hold  <= HW'(1);
                    end
                end
                ARB_HOLD0: begin
                    if (gnt0 && r0.lock && !hold_last) begin
                        hold <= hold + HW'(1);
                    end else begin
                        state <= ARB_FREE;
                        hold  <= '0;
                    end
                end
                ARB_HOLD1: begin
                    if (gnt1 && r1.lock && !hold_last) begin
                        hold <= hold + HW'(1);
                    end else begin
                        state <= ARB_FREE;
                        hold  <= '0;
                    end
                end
                default: begin
                    state <= ARB_FREE;
                    hold  <= '0;
                end
            endcase
        end
    end

    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.m0_rvalid = m0_rvalid_q;
    assign bus.m1_rvalid = m1_rvalid_q;
    assign bus.rdata     = bus.ram_q;
    assign bus.ram_addr  = gnt0 ? r0.addr : (gnt1 ? r1.addr : last_addr);
    assign bus.ram_wr    = gnt1 & bus.m1_wr;
    assign bus.ram_d     = bus.m1_d;

endmodule
